// File: rtl/ld_st_drain_ctrl_if.sv
// Signal bundle between the load/store-buffer drain controller and its neighbours
// (buffer head, memory request/response, cache array, load writeback bus).
interface ld_st_drain_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 32,
    parameter int R_WIDTH    = 6,
    parameter int MICROOP    = 5,
    parameter int ROB_TICKET = 3
);
    logic                  buf_valid;
    logic                  head_isfetched;
    logic [ADDR_BITS-1:0]  head_address;
    logic [DATA_WIDTH-1:0] head_data;
    logic [MICROOP-1:0]    head_microop;
    logic [R_WIDTH-1:0]    head_dest;
    logic [ROB_TICKET-1:0] head_ticket;
    logic                  pop;
    logic                  valid_update;
    logic [ADDR_BITS-1:0]  update_address;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_BITS-1:0]  mem_req_address;
    logic                  mem_resp_valid;
    logic [ADDR_BITS-1:0]  mem_resp_address;
    logic                  cache_rd_en;
    logic [ADDR_BITS-1:0]  cache_rd_addr;
    logic [DATA_WIDTH-1:0] cache_rd_data;
    logic                  cache_wr_en;
    logic [ADDR_BITS-1:0]  cache_wr_addr;
    logic [DATA_WIDTH-1:0] cache_wr_data;
    logic [MICROOP-1:0]    cache_wr_microop;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [R_WIDTH-1:0]    wb_dest;
    logic [ROB_TICKET-1:0] wb_ticket;

    modport master (
        input  buf_valid, head_isfetched, head_address, head_data, head_microop,
               head_dest, head_ticket, mem_req_ready, mem_resp_valid, mem_resp_address,
               cache_rd_data, wb_ready,
        output pop, valid_update, update_address, mem_req_valid, mem_req_address,
               cache_rd_en, cache_rd_addr, cache_wr_en, cache_wr_addr, cache_wr_data,
               cache_wr_microop, wb_valid, wb_data, wb_dest, wb_ticket
    );

    modport slave (
        output buf_valid, head_isfetched, head_address, head_data, head_microop,
               head_dest, head_ticket, mem_req_ready, mem_resp_valid, mem_resp_address,
               cache_rd_data, wb_ready,
        input  pop, valid_update, update_address, mem_req_valid, mem_req_address,
               cache_rd_en, cache_rd_addr, cache_wr_en, cache_wr_addr, cache_wr_data,
               cache_wr_microop, wb_valid, wb_data, wb_dest, wb_ticket
    );
endinterface

// File: rtl/ld_st_drain_ctrl.sv
// Head-drain controller for the non-blocking cache load/store buffer: fetches missing
// blocks, then retires the head (store write / load read+extend+writeback). Macro: LSB_DRAIN_PERF_EN.
module ld_st_drain_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_BITS      = 32,
    parameter int BLOCK_ID_START = 5,
    parameter int R_WIDTH        = 6,
    parameter int MICROOP        = 5,
    parameter int ROB_TICKET     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    ld_st_drain_ctrl_if.master bus
`ifdef LSB_DRAIN_PERF_EN
    ,
    output logic [31:0]        perf_miss_count,
    output logic [31:0]        perf_load_count,
    output logic [31:0]        perf_store_count
`endif
);
    localparam logic [4:0] UOP_LW  = 5'd1;
    localparam logic [4:0] UOP_LH  = 5'd2;
    localparam logic [4:0] UOP_LHU = 5'd3;
    localparam logic [4:0] UOP_LB  = 5'd4;
    localparam logic [4:0] UOP_LBU = 5'd5;
    localparam logic [4:0] UOP_SW  = 5'd6;
    localparam logic [4:0] UOP_SB  = 5'd8;
    localparam int BLK_W = ADDR_BITS - BLOCK_ID_START;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2, S_RD = 3'd3,
        S_CAP  = 3'd4, S_WB  = 3'd5, S_ST   = 3'd6
    } state_t;

    function automatic logic is_load(input logic [MICROOP-1:0] uop);
        return (uop >= UOP_LW) && (uop <= UOP_LBU);
    endfunction

    function automatic logic is_store(input logic [MICROOP-1:0] uop);
        return (uop >= UOP_SW) && (uop <= UOP_SB);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract_load(input logic [DATA_WIDTH-1:0] word,
                                                           input logic [1:0] lane,
                                                           input logic [MICROOP-1:0] uop);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        case (uop)
            UOP_LH:  return {{16{half_v[15]}}, half_v};
            UOP_LHU: return {16'h0000, half_v};
            UOP_LB:  return {{24{byte_v[7]}}, byte_v};
            UOP_LBU: return {24'h00_0000, byte_v};
            default: return word;
        endcase
    endfunction

    state_t                state_q;
    logic                  run_q;
    logic                  pop_q;
    logic                  mem_req_valid_q;
    logic [ADDR_BITS-1:0]  mem_req_address_q;
    logic [BLK_W-1:0]      blk_id_q;
    logic                  cache_rd_en_q;
    logic [ADDR_BITS-1:0]  cache_rd_addr_q;
    logic                  cache_wr_en_q;
    logic [ADDR_BITS-1:0]  cache_wr_addr_q;
    logic [DATA_WIDTH-1:0] cache_wr_data_q;
    logic [MICROOP-1:0]    cache_wr_microop_q;
    logic                  wb_valid_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic [R_WIDTH-1:0]    wb_dest_q;
    logic [ROB_TICKET-1:0] wb_ticket_q;
    logic                  noop_pop;
    logic                  req_fire;
    logic                  wb_fire;

    assign req_fire = mem_req_valid_q & bus.mem_req_ready;
    assign wb_fire  = wb_valid_q & bus.wb_ready;

    // Unknown microops retire in the same IDLE cycle; run_q keeps pop low until reset is released.
    always_comb begin
        noop_pop = 1'b0;
        if ((state_q == S_IDLE) && run_q && bus.buf_valid && bus.head_isfetched &&
            !is_load(bus.head_microop) && !is_store(bus.head_microop)) begin
            noop_pop = 1'b1;
        end else begin
            noop_pop = 1'b0;
        end
    end

    // Drain FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= S_IDLE;
            run_q              <= 1'b0;
            pop_q              <= 1'b0;
            mem_req_valid_q    <= 1'b0;
            mem_req_address_q  <= '0;
            blk_id_q           <= '0;
            cache_rd_en_q      <= 1'b0;
            cache_rd_addr_q    <= '0;
            cache_wr_en_q      <= 1'b0;
            cache_wr_addr_q    <= '0;
            cache_wr_data_q    <= '0;
            cache_wr_microop_q <= '0;
            wb_valid_q         <= 1'b0;
            wb_data_q          <= '0;
            wb_dest_q          <= '0;
            wb_ticket_q        <= '0;
        end else begin
            run_q         <= 1'b1;
            pop_q         <= 1'b0;
            cache_rd_en_q <= 1'b0;
            cache_wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run_q && bus.buf_valid && !bus.head_isfetched) begin
                        state_q           <= S_REQ;
                        mem_req_valid_q   <= 1'b1;
                        mem_req_address_q <= {bus.head_address[ADDR_BITS-1:BLOCK_ID_START],
                                              {BLOCK_ID_START{1'b0}}};
                    end else if (run_q && bus.buf_valid && is_store(bus.head_microop)) begin
                        state_q            <= S_ST;
                        cache_wr_en_q      <= 1'b1;
                        pop_q              <= 1'b1;
                        cache_wr_addr_q    <= bus.head_address;
                        cache_wr_data_q    <= bus.head_data;
                        cache_wr_microop_q <= bus.head_microop;
                    end else if (run_q && bus.buf_valid && is_load(bus.head_microop)) begin
                        state_q         <= S_RD;
                        cache_rd_en_q   <= 1'b1;
                        cache_rd_addr_q <= bus.head_address;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (req_fire) begin
                        state_q         <= S_WAIT;
                        mem_req_valid_q <= 1'b0;
                        blk_id_q        <= mem_req_address_q[ADDR_BITS-1:BLOCK_ID_START];
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid &&
                        (bus.mem_resp_address[ADDR_BITS-1:BLOCK_ID_START] == blk_id_q)) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_RD: begin
                    state_q <= S_CAP;
                end
                // Read data is valid this cycle; the head entry is still in place.
                S_CAP: begin
                    state_q     <= S_WB;
                    wb_valid_q  <= 1'b1;
                    wb_data_q   <= extract_load(bus.cache_rd_data, bus.head_address[1:0],
                                                bus.head_microop);
                    wb_dest_q   <= bus.head_dest;
                    wb_ticket_q <= bus.head_ticket;
                end
                S_WB: begin
                    if (bus.wb_ready) begin
                        state_q    <= S_IDLE;
                        wb_valid_q <= 1'b0;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_ST: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q         <= S_IDLE;
                    mem_req_valid_q <= 1'b0;
                    wb_valid_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pop              = pop_q | noop_pop | wb_fire;
    assign bus.valid_update     = bus.mem_resp_valid;
    assign bus.update_address   = bus.mem_resp_address;
    assign bus.mem_req_valid    = mem_req_valid_q;
    assign bus.mem_req_address  = mem_req_address_q;
    assign bus.cache_rd_en      = cache_rd_en_q;
    assign bus.cache_rd_addr    = cache_rd_addr_q;
    assign bus.cache_wr_en      = cache_wr_en_q;
    assign bus.cache_wr_addr    = cache_wr_addr_q;
    assign bus.cache_wr_data    = cache_wr_data_q;
    assign bus.cache_wr_microop = cache_wr_microop_q;
    assign bus.wb_valid         = wb_valid_q;
    assign bus.wb_data          = wb_data_q;
    assign bus.wb_dest          = wb_dest_q;
    assign bus.wb_ticket        = wb_ticket_q;

`ifdef LSB_DRAIN_PERF_EN
    logic [31:0] perf_miss_q;
    logic [31:0] perf_load_q;
    logic [31:0] perf_store_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_miss_q  <= 32'd0;
            perf_load_q  <= 32'd0;
            perf_store_q <= 32'd0;
        end else begin
            if ((state_q == S_REQ) && req_fire && (perf_miss_q != 32'hFFFF_FFFF)) begin
                perf_miss_q <= perf_miss_q + 32'd1;
            end else begin
                perf_miss_q <= perf_miss_q;
            end
            if ((state_q == S_WB) && wb_fire && (perf_load_q != 32'hFFFF_FFFF)) begin
                perf_load_q <= perf_load_q + 32'd1;
            end else begin
                perf_load_q <= perf_load_q;
            end
            if ((state_q == S_ST) && (perf_store_q != 32'hFFFF_FFFF)) begin
                perf_store_q <= perf_store_q + 32'd1;
            end else begin
                perf_store_q <= perf_store_q;
            end
        end
    end

    assign perf_miss_count  = perf_miss_q;
    assign perf_load_count  = perf_load_q;
    assign perf_store_count = perf_store_q;
`endif
endmodule
